// File: rtl/wimpfi_pkg.sv
// Shared types and constants for the transmit-source arbiter.
package wimpfi_pkg;

  localparam logic [7:0] EOT_DEFAULT = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_MORE,
    WAIT_BUSY
  } arb_state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Per-channel first-word-fall-through byte FIFO; DEPTH must be a power of 2 (>= 2).
module byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/tx_source_arbiter.sv
// Frame arbiter: NCH buffered byte channels into one transmitter, whole EOT-terminated frames.
// TX_ARB_STRICT_PRIO_EN selects lowest-index-first grants instead of round-robin.
module tx_source_arbiter
  import wimpfi_pkg::*;
#(
  parameter int           NCH   = 2,
  parameter int           W     = 8,
  parameter int           DEPTH = 32,
  parameter logic [W-1:0] EOT   = W'(EOT_DEFAULT),
  parameter int           HOLD  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NCH*W-1:0]              in_data,
  input  logic [NCH-1:0]                in_wr,
  output logic [NCH-1:0]                in_full,
  output logic [NCH-1:0]                ovf,
  input  logic                          xrdy,
  output logic [W-1:0]                  xdata,
  output logic                          xwr,
  output logic                          xsend,
  output logic [clog2_min1(NCH)-1:0]    active_ch,
  output logic                          busy
);

  localparam int AW = clog2_min1(NCH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = clog2_min1(HOLD);

  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] fifo_empty;
  logic [NCH-1:0] fifo_full;
  logic [NCH-1:0] elig;
  logic [W-1:0]   fifo_dout [NCH];
  logic [NCH-1:0] ovf_q;

  arb_state_t     state_q, state_d;
  logic [AW-1:0]  grant_q, grant_d;
  logic [AW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]  next_ptr;
  logic [AW-1:0]  pick;
  logic           pick_valid;
  logic [HW-1:0]  hold_q, hold_d;
  logic           xwr_q, xwr_d;
  logic           xsend_q, xsend_d;
  logic [W-1:0]   xdata_q, xdata_d;
  logic [W-1:0]   cur_byte;
  logic           cur_empty;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] fcnt_q;
      logic          push_eot;
      logic          pop_eot;

      assign push[gi] = in_wr[gi] && !fifo_full[gi];
      assign pop[gi]  = (state_q == STREAM) && (grant_q == AW'(gi)) && !fifo_empty[gi];

      byte_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .din   (in_data[gi*W +: W]),
        .dout  (fifo_dout[gi]),
        .empty (fifo_empty[gi]),
        .full  (fifo_full[gi])
      );

      assign push_eot = push[gi] && (in_data[gi*W +: W] == EOT);
      assign pop_eot  = pop[gi] && (fifo_dout[gi] == EOT);

      // Complete frames buffered; a full FIFO also qualifies so over-long frames cannot deadlock.
      assign elig[gi] = (fcnt_q != '0) || fifo_full[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          fcnt_q <= '0;
        end else begin
          case ({push_eot, pop_eot})
            2'b10:   fcnt_q <= fcnt_q + CW'(1);
            2'b01:   fcnt_q <= fcnt_q - CW'(1);
            default: fcnt_q <= fcnt_q;
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_q | (in_wr & fifo_full);
    end
  end

`ifdef TX_ARB_STRICT_PRIO_EN
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick       = AW'(i);
        pick_valid = 1'b1;
      end
    end
  end
`else
  logic [2*NCH-1:0] elig2;
  logic [NCH-1:0]   rot;
  logic [AW:0]      sum;

  // Rotate eligibility so bit 0 is the pointer, then map the first hit back to a channel.
  always_comb begin
    elig2      = {elig, elig};
    rot        = elig2[rr_ptr_q +: NCH];
    sum        = '0;
    pick_valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum        = {1'b0, rr_ptr_q} + (AW+1)'(i);
        pick_valid = 1'b1;
      end
    end
    if (sum >= (AW+1)'(NCH)) begin
      sum = sum - (AW+1)'(NCH);
    end
    pick = sum[AW-1:0];
  end
`endif

  assign cur_byte  = fifo_dout[grant_q];
  assign cur_empty = fifo_empty[grant_q];
  assign next_ptr  = (grant_q == AW'(NCH - 1)) ? '0 : grant_q + AW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    xwr_d    = 1'b0;
    xsend_d  = 1'b0;
    xdata_d  = xdata_q;
    case (state_q)
      IDLE: begin
        if (xrdy && pick_valid) begin
          grant_d = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!cur_empty) begin
          xwr_d   = 1'b1;
          xdata_d = cur_byte;
          if (cur_byte == EOT) begin
            xsend_d  = 1'b1;
            rr_ptr_d = next_ptr;
            hold_d   = '0;
            state_d  = WAIT_BUSY;
          end
        end else begin
          state_d = WAIT_MORE;
        end
      end
      WAIT_MORE: begin
        if (!cur_empty) begin
          state_d = STREAM;
        end
      end
      WAIT_BUSY: begin
        // Give the transmitter up to HOLD cycles to drop xrdy after the send.
        if (!xrdy || (hold_q == HW'(HOLD - 1))) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      xwr_q    <= 1'b0;
      xsend_q  <= 1'b0;
      xdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      xwr_q    <= xwr_d;
      xsend_q  <= xsend_d;
      xdata_q  <= xdata_d;
    end
  end

  assign in_full   = fifo_full;
  assign ovf       = ovf_q;
  assign xwr       = xwr_q;
  assign xsend     = xsend_q;
  assign xdata     = xdata_q;
  assign active_ch = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tx_source_arbiter.sv
// Scenario bench for tx_source_arbiter: per-channel byte scoreboards plus frame-order queue.
module tb_tx_source_arbiter;

  localparam int NCH   = 2;
  localparam int W     = 8;
  localparam int DEPTH = 32;
  localparam int HOLD  = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NCH*W-1:0]   in_data = '0;
  logic [NCH-1:0]     in_wr = '0;
  logic [NCH-1:0]     in_full;
  logic [NCH-1:0]     ovf;
  logic               xrdy = 1'b0;
  logic [W-1:0]       xdata;
  logic               xwr;
  logic               xsend;
  logic [0:0]         active_ch;
  logic               busy;

  tx_source_arbiter #(
    .NCH   (NCH),
    .W     (W),
    .DEPTH (DEPTH),
    .HOLD  (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_wr     (in_wr),
    .in_full   (in_full),
    .ovf       (ovf),
    .xrdy      (xrdy),
    .xdata     (xdata),
    .xwr       (xwr),
    .xsend     (xsend),
    .active_ch (active_ch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cycle_n = 0;
  int         xwr_cnt = 0;
  int         send_cnt = 0;
  int         frame_start_cyc = 0;
  int         last_send_cyc = 0;
  bit         in_frame = 1'b0;
  logic [0:0] frame_ch = '0;
  logic [7:0] exq0[$];
  logic [7:0] exq1[$];
  int         exp_fr[$];

  // One clock step; samples #1 after the edge and scores any transmitter write.
  task automatic cyc();
    logic [7:0] e;
    bit         have;
    @(posedge clk);
    #1;
    cycle_n++;
    if (xwr === 1'b1) begin
      if (!in_frame) begin
        in_frame        = 1'b1;
        frame_ch        = active_ch;
        frame_start_cyc = cycle_n;
        if (exp_fr.size() > 0) begin
          int f;
          f = exp_fr.pop_front();
          checks++;
          if (active_ch !== 1'(f)) begin
            errors++;
            $display("FAIL grant_order: active_ch=%0d expected %0d at cycle %0d", active_ch, f, cycle_n);
          end
        end
      end else begin
        checks++;
        if (active_ch !== frame_ch) begin
          errors++;
          $display("FAIL no_interleave: active_ch=%0d expected %0d at cycle %0d", active_ch, frame_ch, cycle_n);
        end
      end
      have = 1'b0;
      e    = '0;
      if (active_ch === 1'b0 && exq0.size() > 0) begin
        e = exq0.pop_front(); have = 1'b1;
      end else if (active_ch === 1'b1 && exq1.size() > 0) begin
        e = exq1.pop_front(); have = 1'b1;
      end
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_xwr: ch=%0d data=%02h at cycle %0d, nothing expected", active_ch, xdata, cycle_n);
      end else if (xdata !== e || xsend !== (e == 8'h04)) begin
        errors++;
        $display("FAIL xbyte: ch=%0d data=%02h xsend=%0b expected data=%02h xsend=%0b at cycle %0d",
                 active_ch, xdata, xsend, e, (e == 8'h04), cycle_n);
      end else begin
        $display("cycle %0d: ch%0d xdata=%02h xsend=%0b ok", cycle_n, active_ch, xdata, xsend);
      end
      xwr_cnt++;
      if (xsend === 1'b1) begin
        in_frame      = 1'b0;
        send_cnt++;
        last_send_cyc = cycle_n;
      end
    end else if (xsend !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL xsend_alone: xsend=%0b with xwr=%0b at cycle %0d", xsend, xwr, cycle_n);
    end
  endtask

  task automatic wr(input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1, input bit expect_out);
    in_wr   = en;
    in_data = {d1, d0};
    if (expect_out && en[0]) exq0.push_back(d0);
    if (expect_out && en[1]) exq1.push_back(d1);
    cyc();
    in_wr = '0;
  endtask

  task automatic wait_send(input int budget, input string what);
    int start;
    start = send_cnt;
    for (int i = 0; i < budget && send_cnt == start; i++) cyc();
    checks++;
    if (send_cnt == start) begin
      errors++;
      $display("FAIL timeout_%s: no xsend within %0d cycles", what, budget);
    end
  endtask

  task automatic do_reset();
    in_wr = '0;
    reset = 1'b1;
    exq0.delete();
    exq1.delete();
    exp_fr.delete();
    in_frame = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    xrdy = 1'b0;
    do_reset();
    cyc();
    checks++; if (xwr !== 1'b0)     begin errors++; $display("FAIL rst_xwr: got %0b want 0", xwr); end
    checks++; if (xsend !== 1'b0)   begin errors++; $display("FAIL rst_xsend: got %0b want 0", xsend); end
    checks++; if (xdata !== 8'h00)  begin errors++; $display("FAIL rst_xdata: got %02h want 00", xdata); end
    checks++; if (ovf !== 2'b00)    begin errors++; $display("FAIL rst_ovf: got %b want 00", ovf); end
    checks++; if (active_ch !== 1'b0) begin errors++; $display("FAIL rst_active_ch: got %0d want 0", active_ch); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (in_full !== 2'b00) begin errors++; $display("FAIL rst_in_full: got %b want 00", in_full); end
    $display("reset: outputs checked at cycle %0d", cycle_n);
  endtask

  task automatic test_basic_frame();
    int k;
    xrdy = 1'b1;
    exp_fr.push_back(0);
    wr(2'b01, 8'h41, 8'h00, 1'b1);
    wr(2'b01, 8'h42, 8'h00, 1'b1);
    wr(2'b01, 8'h04, 8'h00, 1'b1);
    k = cycle_n;
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_grant: busy=%0b want 1 at edge k+1", busy); end
    wait_send(20, "basic");
    checks++;
    if (frame_start_cyc != k + 2) begin
      errors++; $display("FAIL basic_latency: first xwr at %0d want %0d", frame_start_cyc, k + 2);
    end
    checks++;
    if (last_send_cyc != k + 4) begin
      errors++; $display("FAIL basic_stream: xsend at %0d want %0d", last_send_cyc, k + 4);
    end
    xrdy = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_wait_busy: busy=%0b want 0 after xrdy fell", busy); end
    $display("basic frame: done at cycle %0d", cycle_n);
  endtask

  task automatic test_round_robin();
    do_reset();
    xrdy = 1'b0;
    exp_fr.push_back(0);
    exp_fr.push_back(1);
    wr(2'b11, 8'h51, 8'h71, 1'b1);
    wr(2'b11, 8'h52, 8'h72, 1'b1);
    wr(2'b11, 8'h04, 8'h04, 1'b1);
    xrdy = 1'b1;
    wait_send(20, "rr_a1");
    wait_send(20, "rr_a2");
    checks++;
    if (exq0.size() != 0 || exq1.size() != 0) begin
      errors++; $display("FAIL rr_drain: left ch0=%0d ch1=%0d want 0", exq0.size(), exq1.size());
    end
    exp_fr.push_back(0);
    wr(2'b01, 8'h31, 8'h00, 1'b1);
    wr(2'b01, 8'h04, 8'h00, 1'b1);
    wait_send(20, "rr_b0");
    xrdy = 1'b0;
    cyc();
`ifdef TX_ARB_STRICT_PRIO_EN
    exp_fr.push_back(0);
    exp_fr.push_back(1);
`else
    exp_fr.push_back(1);
    exp_fr.push_back(0);
`endif
    wr(2'b11, 8'h53, 8'h73, 1'b1);
    wr(2'b11, 8'h04, 8'h04, 1'b1);
    xrdy = 1'b1;
    wait_send(20, "rr_b1");
    wait_send(20, "rr_b2");
    checks++;
    if (exp_fr.size() != 0) begin errors++; $display("FAIL rr_order_left: %0d frames not seen", exp_fr.size()); end
    $display("round robin: done at cycle %0d", cycle_n);
  endtask

  task automatic test_overflow();
    int start;
    xrdy = 1'b0;
    repeat (2) cyc();
    for (int i = 0; i < DEPTH; i++) wr(2'b10, 8'h00, 8'(8'h80 + i), 1'b1);
    checks++; if (in_full !== 2'b10) begin errors++; $display("FAIL ovf_full: in_full=%b want 10", in_full); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL ovf_early: ovf=%b want 00", ovf); end
    wr(2'b10, 8'h00, 8'hEE, 1'b0);
    checks++; if (ovf !== 2'b10) begin errors++; $display("FAIL ovf_set: ovf=%b want 10", ovf); end
    exp_fr.push_back(1);
    exp_fr.push_back(0);
    start = xwr_cnt;
    xrdy  = 1'b1;
    wr(2'b01, 8'h61, 8'h00, 1'b1);
    wr(2'b01, 8'h62, 8'h00, 1'b1);
    wr(2'b01, 8'h04, 8'h00, 1'b1);
    for (int i = 0; i < 60 && xwr_cnt - start < DEPTH; i++) cyc();
    checks++;
    if (xwr_cnt - start != DEPTH) begin
      errors++; $display("FAIL ovf_stream_count: %0d bytes want %0d", xwr_cnt - start, DEPTH);
    end
    checks++;
    if (cycle_n != frame_start_cyc + DEPTH - 1) begin
      errors++; $display("FAIL ovf_stream_rate: last byte at %0d want %0d", cycle_n, frame_start_cyc + DEPTH - 1);
    end
    $display("overflow: ch1 streamed %0d bytes by cycle %0d", xwr_cnt - start, cycle_n);
  endtask

  task automatic test_starvation();
    int s;
    s = xwr_cnt;
    repeat (20) cyc();
    checks++; if (xwr_cnt != s) begin errors++; $display("FAIL starve_quiet: %0d writes want 0", xwr_cnt - s); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL starve_busy: busy=%0b want 1", busy); end
    checks++; if (active_ch !== 1'b1) begin errors++; $display("FAIL starve_lock: active_ch=%0d want 1", active_ch); end
    wr(2'b10, 8'h00, 8'h04, 1'b1);
    wait_send(10, "starve_ch1");
    wait_send(20, "starve_ch0");
    checks++; if (ovf !== 2'b10) begin errors++; $display("FAIL ovf_sticky: ovf=%b want 10", ovf); end
    $display("starvation: done at cycle %0d", cycle_n);
  endtask

  task automatic test_xrdy_gating();
    int s;
    xrdy = 1'b0;
    cyc();
    exp_fr.push_back(0);
    wr(2'b01, 8'hA1, 8'h00, 1'b1);
    wr(2'b01, 8'h04, 8'h00, 1'b1);
    repeat (5) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_hold: busy=%0b want 0 with xrdy low", busy); end
    xrdy = 1'b1;
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_grant: busy=%0b want 1", busy); end
    wait_send(10, "gate");
    s = last_send_cyc;
    repeat (HOLD - 1) cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_early: busy=%0b want 1 at s+%0d", busy, cycle_n - s); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_timeout: busy=%0b want 0 at s+%0d", busy, cycle_n - s); end
    $display("xrdy gating: done at cycle %0d", cycle_n);
  endtask

  task automatic test_reset_mid_stream();
    int start;
    int s;
    xrdy  = 1'b1;
    exp_fr.push_back(0);
    start = xwr_cnt;
    wr(2'b01, 8'h11, 8'h00, 1'b1);
    wr(2'b01, 8'h12, 8'h00, 1'b1);
    wr(2'b01, 8'h13, 8'h00, 1'b1);
    wr(2'b01, 8'h14, 8'h00, 1'b1);
    wr(2'b01, 8'h04, 8'h00, 1'b1);
    for (int i = 0; i < 20 && xwr_cnt - start < 2; i++) cyc();
    checks++; if (xwr_cnt - start != 2) begin errors++; $display("FAIL rst_mid_reach: %0d bytes want 2", xwr_cnt - start); end
    reset = 1'b1;
    #1;
    checks++; if (xwr !== 1'b0) begin errors++; $display("FAIL rst_mid_xwr: xwr=%0b want 0 right after reset", xwr); end
    exq0.delete();
    exq1.delete();
    exp_fr.delete();
    in_frame = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: busy=%0b want 0", busy); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL rst_mid_ovf: ovf=%b want 00", ovf); end
    s = xwr_cnt;
    repeat (10) cyc();
    checks++;
    if (xwr_cnt != s || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_fcnt: writes=%0d busy=%0b want 0 and 0", xwr_cnt - s, busy);
    end
    $display("reset mid-stream: done at cycle %0d", cycle_n);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_round_robin();
    test_overflow();
    test_starvation();
    test_xrdy_gating();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
